// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load requests, load result, data-memory port, occupancy.
// Latency: n/a (signal bundle only).
// Backpressure: st_ready from the buffer; ld_stall tells the MEM stage to hold the load.
//
// Ports (by modport):
//   master : drives st_valid/st_addr/st_data, ld_valid/ld_addr; observes everything else
//   slave  : the store buffer itself (opposite directions)
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // store request
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;

  // load request and result
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_fwd_data;
  logic              ld_stall;

  // single data-memory port
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;

  // occupancy for fences
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall,
    input  mem_read, mem_write, mem_address, mem_write_data,
    input  empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_hit, ld_fwd_data, ld_stall,
    output mem_read, mem_write, mem_address, mem_write_data,
    output empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of committed stores draining to a single data-memory port.
// Latency: a pushed store is visible to load matching next cycle; drains one entry per free port cycle.
// Backpressure: st_ready drops when full; ld_stall holds a load when full (or on a match without forwarding).
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; clears pointers, count and entry valid bits
//   bus   : store_buffer_if.slave (store/load requests, load result, memory port, occupancy)
//
// Optional feature: define STORE_BUFFER_FWD_EN to forward the youngest matching store's data to
// a load instead of stalling it until the matching entries have drained.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // entry storage; payload is only meaningful where valid_q is set, so it carries no reset
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              full;
  logic              push;
  logic              drain;
  logic              load_owns;
  logic              ld_match;
  logic [PTR_W-1:0]  idx;
`ifdef STORE_BUFFER_FWD_EN
  logic [DATA_W-1:0] match_data;
`endif

  logic              hit;
  logic              stall;
  logic [DATA_W-1:0] fwd_data;

  assign full = (count_q == FULL_CNT);
  assign push = bus.st_valid && !full;

  // Walk entries oldest to youngest starting at head, so the last hit seen is the youngest.
  always_comb begin
    ld_match = 1'b0;
    idx      = '0;
`ifdef STORE_BUFFER_FWD_EN
    match_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == bus.ld_addr)) begin
        ld_match = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        match_data = data_q[idx];
`endif
      end
    end
  end

  // A non-matching load takes the port unless the buffer is full; in every other case the
  // port is free for the head entry.
  assign load_owns = bus.ld_valid && !ld_match && !full;
  assign drain     = (count_q != '0) && !load_owns;

`ifdef STORE_BUFFER_FWD_EN
  // Forwarding needs no port, so the head keeps draining while the load is served.
  // A full buffer still stalls the load so the MEM stage sees one consistent rule.
  assign hit      = bus.ld_valid && ld_match && !full;
  assign stall    = bus.ld_valid && full;
  assign fwd_data = hit ? match_data : '0;
`else
  // Without forwarding a matching load waits until every matching entry has been written.
  assign hit      = 1'b0;
  assign stall    = bus.ld_valid && (full || ld_match);
  assign fwd_data = '0;
`endif

  // pointers, occupancy and valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      // push and pop never hit the same slot: pop needs count>0, push needs count<DEPTH,
      // and with both true head != tail
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({push, drain})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // payload capture
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

  // outputs: all combinational from current state and the load inputs
  assign bus.st_ready       = !full;
  assign bus.empty          = (count_q == '0);
  assign bus.count          = count_q;
  assign bus.mem_read       = load_owns;
  assign bus.mem_write      = drain;
  assign bus.mem_address    = load_owns ? bus.ld_addr : (drain ? addr_q[head_q] : '0);
  assign bus.mem_write_data = drain ? data_q[head_q] : '0;
  assign bus.ld_hit         = hit;
  assign bus.ld_stall       = stall;
  assign bus.ld_fwd_data    = fwd_data;
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning word address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning store data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports st_valid  input  1, st_addr  input  ADDR_W, st_data  input  DATA_W: store request from the MEM stage.
REQ-007 SHALL have port st_ready  output  1  store accepted this cycle when high with st_valid.
REQ-008 SHALL have ports ld_valid  input  1, ld_addr  input  ADDR_W: load request from the MEM stage.
REQ-009 SHALL have ports ld_hit  output  1, ld_fwd_data  output  DATA_W, ld_stall  output  1: load forward/stall result.
REQ-010 SHALL have ports mem_read  output  1, mem_write  output  1, mem_address  output  ADDR_W, mem_write_data  output  DATA_W: single data-memory port.
REQ-011 SHALL have ports empty  output  1 and count  output  $clog2(DEPTH)+1: occupancy, for fences.

Function
REQ-012 SHALL hold entries in a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-013 SHALL drive st_ready = (count < DEPTH); push occurs at the clock edge when st_valid && st_ready.
REQ-014 SHALL compare addresses on all ADDR_W bits (word addressing).
REQ-015 SHALL, when ld_valid and no entry matches ld_addr and count < DEPTH, drive mem_read=1, mem_address=ld_addr, mem_write=0, ld_stall=0, ld_hit=0 (load owns the port).
REQ-016 SHALL, when count == DEPTH and ld_valid, drive ld_stall=1, mem_read=0, and drain the head (full buffer beats the load).
REQ-017 SHALL drain when count > 0 and the port is not owned by a load: mem_write=1, mem_address/mem_write_data = head entry, head popped at the same edge the memory captures the write.
REQ-018 SHALL, on simultaneous push and pop, keep count unchanged; a push never bypasses the FIFO to memory in the same cycle.
REQ-019 SHALL drive mem_read, mem_write, mem_address, mem_write_data combinationally from current state and load inputs; mem_read and mem_write never both 1.
REQ-020 SHALL drive mem_address and mem_write_data to 0 when neither mem_read nor mem_write.
REQ-021 SHALL drive empty = (count == 0); count never exceeds DEPTH nor underflows.
REQ-022 SHALL treat a store pushed in cycle N as visible to match logic from cycle N+1.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear head, tail, count and all entry valid bits.
REQ-024 SHALL hold outputs during and after reset at: st_ready=1, empty=1, count=0, mem_write=0, ld_hit=0, ld_stall=0; mem_read follows REQ-015.
REQ-025 SHALL discard all pending stores on reset mid-drain; no partial write is issued after rst_n falls.

Configuration
REQ-026 SHALL use macro STORE_BUFFER_FWD_EN to select load-forwarding.
REQ-027 SHALL, with STORE_BUFFER_FWD_EN defined, on a load match set ld_hit=1, ld_fwd_data = data of the youngest matching entry, mem_read=0, ld_stall=0, and drain in that cycle.
REQ-028 SHALL, without STORE_BUFFER_FWD_EN, on a load match set ld_stall=1, ld_hit=0, ld_fwd_data=0, mem_read=0, and drain every cycle until no entry matches.

Verification
REQ-029 SHALL verify reset: rst_n=0 with 3 entries queued -> count=0, empty=1, mem_write=0 immediately; no write of queued data afterward.
REQ-030 SHALL verify fill/drain: 4 stores (addr 0x10..0x13, data 0xA0..0xA3) back-to-back with ld_valid=1 to non-matching 0x40 -> st_ready=0 at count=4, ld_stall=1, writes emerge in order 0x10..0x13.
REQ-031 SHALL verify forwarding (macro on): stores 0x20=0x1111 then 0x20=0x2222, load 0x20 -> ld_hit=1, ld_fwd_data=0x2222, mem_read=0.
REQ-032 SHALL verify stall (macro off): store 0x20=0x1111, load 0x20 next cycle -> ld_stall=1 until write of 0x20 completes, then mem_read=1, address 0x20.
REQ-033 SHALL verify simultaneous push/pop at count=2 -> count stays 2; tail and head wrap correctly past DEPTH-1 over 10 stores.
REQ-034 SHALL verify port exclusivity over random traffic: mem_read && mem_write never asserted together; final memory contents equal last store per address.
